pwm_duty_sequencer: RTL and testbench
=====================================

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 50000, meaning CLK cycles per breathing step (1 ms at 50 MHz), legal range 2..2^20-1.
REQ-002 SHALL have parameter STEP_SIZE, default 8'd4, meaning duty increment/decrement per breathing step, legal range 1..255.
REQ-003 SHALL have parameter HOLD_STEPS, default 8'd50, meaning step periods held at each breathing extreme, legal range 1..255.
REQ-004 SHALL have port CLK input 1, meaning sole clock; all logic on its rising edge.
REQ-005 SHALL have port RST input 1, meaning synchronous active-high reset.
REQ-006 SHALL have port key_pulse input 4, meaning one-cycle debounced commands: [0] duty+10, [1] duty-10, [2] breathing start/stop toggle, [3] duty=127.
REQ-007 SHALL have port duty output 8, meaning registered duty value for the downstream PWM generator.
REQ-008 SHALL have port duty_upd output 1, meaning one-cycle strobe, high exactly in the first cycle in which duty shows a changed value.
REQ-009 SHALL have port breathing output 1, meaning high while the FSM is in any breathing state.

Function
REQ-010 SHALL implement FSM states MANUAL, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO.
REQ-011 SHALL resolve simultaneous key bits with priority [2] > [3] > [0] > [1]; lower-priority bits in the same cycle are ignored.
REQ-012 SHALL, in MANUAL on key[0], set duty = min(duty+10, 255) using 9-bit intermediate arithmetic, with no wrap.
REQ-013 SHALL, in MANUAL on key[1], set duty = max(duty-10, 0), with no wrap.
REQ-014 SHALL, on key[3] in any state, set duty=127 and enter MANUAL.
REQ-015 SHALL, on key[2] in MANUAL, enter RAMP_UP with duty unchanged and clear the tick counter and hold counter.
REQ-016 SHALL, on key[2] in any breathing state, enter MANUAL, freezing duty at its current value.
REQ-017 SHALL, on key[0] or key[1] in a breathing state, enter MANUAL and apply the ±10 rule to the current duty in the same cycle.
REQ-018 SHALL count ticks 0..STEP_TICKS-1 in breathing states only, wrapping to 0; a step event occurs in the cycle the count equals STEP_TICKS-1.
REQ-019 SHALL, on a step event in RAMP_UP, set duty = min(duty+STEP_SIZE, 255); when the result is 255, enter HOLD_HI.
REQ-020 SHALL, on a step event in RAMP_DOWN, set duty = max(duty-STEP_SIZE, 0); when the result is 0, enter HOLD_LO.
REQ-021 SHALL, in HOLD_HI/HOLD_LO, count step events; on the HOLD_STEPS-th event, clear the hold counter and enter RAMP_DOWN/RAMP_UP respectively, with duty unchanged.
REQ-022 SHALL, on entering RAMP_UP with duty already 255, apply the step event and enter HOLD_HI without changing duty; symmetric behaviour for RAMP_DOWN at 0.
REQ-023 SHALL give a key command priority over a step event in the same cycle; the step is discarded.
REQ-024 SHALL register duty_upd as (next_duty != duty), so that a saturated no-change command produces no strobe.
REQ-025 SHALL have a latency of one cycle from key_pulse or step event to the new duty, duty_upd and breathing values.

Reset
REQ-026 SHALL, while RST is high at a CLK edge, set state=MANUAL, duty=0, duty_upd=0, breathing=0, tick counter=0, hold counter=0.
REQ-027 SHALL give RST priority over all key_pulse bits and step events, including mid-ramp and mid-hold.
REQ-028 SHALL produce no duty_upd strobe on reset or on the first cycle after reset.

Structure
REQ-029 SHALL place the FSM state encoding and the constants 10 (manual step), 127 (half duty) and 255 (max duty) in the shared pwm package.
REQ-030 SHALL be a single module with no sub-modules; the tick counter is a natural candidate for a generic tick_divider sub-module, reused unchanged when one exists.

Verification (STEP_TICKS=4, STEP_SIZE=64, HOLD_STEPS=2)
REQ-031 SHALL cover: reset, then key[0] ×3 -> duty 10, 20, 30, each with a single-cycle duty_upd.
REQ-032 SHALL cover: duty=250, key[0] -> 255 with strobe; key[0] again -> 255 with no strobe; duty=5, key[1] -> 0.
REQ-033 SHALL cover: key[2] at duty=0 -> breathing=1; duty 64, 128, 192, 255 at 4-cycle intervals; held 8 cycles; then 191, 127, 63, 0.
REQ-034 SHALL cover: key[0] and key[1] and key[3] asserted in the same cycle -> duty=127, state MANUAL.
REQ-035 SHALL cover: key[1] coincident with a RAMP_UP step at duty=128 -> duty=118, breathing=0.
REQ-036 SHALL cover: RST asserted during HOLD_HI -> next cycle duty=0, breathing=0, duty_upd=0.

Source files
------------

// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared PWM definitions: sequencer states,
// duty constants and saturating duty helpers.
package pwm_duty_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_MANUAL,
        ST_RAMP_UP,
        ST_HOLD_HI,
        ST_RAMP_DOWN,
        ST_HOLD_LO
    } pwm_state_e;

    localparam logic [7:0] DUTY_STEP = 8'd10;
    localparam logic [7:0] DUTY_HALF = 8'd127;
    localparam logic [7:0] DUTY_MAX  = 8'd255;

    // Add with a 9-bit intermediate, clamping at full scale.
    function automatic logic [7:0] sat_add(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? DUTY_MAX : s[7:0];
    endfunction

    // Subtract, clamping at zero.
    function automatic logic [7:0] sat_sub(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer: manual key control plus an
// automatic breathing ramp with holds at the extremes.
module pwm_duty_sequencer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int unsigned STEP_TICKS = 50000,
    parameter logic [7:0]  STEP_SIZE  = 8'd4,
    parameter logic [7:0]  HOLD_STEPS = 8'd50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] key_pulse,
    output logic [7:0] duty,
    output logic       duty_upd,
    output logic       breathing
);

    localparam int TW = 20;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    pwm_state_e    state_q;
    pwm_state_e    state_d;
    logic [7:0]    duty_d;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic [TW-1:0] tick_wrap;
    logic [7:0]    hold_q;
    logic [7:0]    hold_d;
    logic          in_breath;
    logic          step;
    logic          start;

    // Next state, next duty and counter updates; keys outrank steps.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty;
        hold_d    = hold_q;
        in_breath = (state_q != ST_MANUAL);
        step      = in_breath && (tick_q == TICK_LAST);
        start     = key_pulse[2] && !in_breath;
        tick_wrap = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

        priority case (1'b1)
            key_pulse[2]: begin
                if (in_breath) begin
                    state_d = ST_MANUAL;
                end else begin
                    state_d = ST_RAMP_UP;
                    hold_d  = '0;
                end
            end
            key_pulse[3]: begin
                duty_d  = DUTY_HALF;
                state_d = ST_MANUAL;
            end
            key_pulse[0]: begin
                duty_d  = sat_add(duty, DUTY_STEP);
                state_d = ST_MANUAL;
            end
            key_pulse[1]: begin
                duty_d  = sat_sub(duty, DUTY_STEP);
                state_d = ST_MANUAL;
            end
            default: begin
                if (step) begin
                    unique case (state_q)
                        ST_RAMP_UP: begin
                            duty_d = sat_add(duty, STEP_SIZE);
                            if (duty_d == DUTY_MAX) begin
                                state_d = ST_HOLD_HI;
                            end
                        end
                        ST_RAMP_DOWN: begin
                            duty_d = sat_sub(duty, STEP_SIZE);
                            if (duty_d == 8'd0) begin
                                state_d = ST_HOLD_LO;
                            end
                        end
                        ST_HOLD_HI: begin
                            if (hold_q == HOLD_STEPS - 8'd1) begin
                                hold_d  = '0;
                                state_d = ST_RAMP_DOWN;
                            end else begin
                                hold_d = hold_q + 8'd1;
                            end
                        end
                        ST_HOLD_LO: begin
                            if (hold_q == HOLD_STEPS - 8'd1) begin
                                hold_d  = '0;
                                state_d = ST_RAMP_UP;
                            end else begin
                                hold_d = hold_q + 8'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase

        // The tick count only runs while breathing continues.
        if (state_d == ST_MANUAL || start) begin
            tick_d = '0;
        end else begin
            tick_d = tick_wrap;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_MANUAL;
            duty      <= 8'd0;
            duty_upd  <= 1'b0;
            breathing <= 1'b0;
            tick_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            duty      <= duty_d;
            duty_upd  <= (duty_d != duty);
            breathing <= (state_d != ST_MANUAL);
            tick_q    <= tick_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer with a
// small breathing model and directed scenario checks.
module tb_pwm_duty_sequencer;

    localparam int ST = 4;
    localparam int SS = 64;
    localparam int HS = 2;

    logic       CLK;
    logic       RST;
    logic [3:0] key_pulse;
    logic [7:0] duty;
    logic       duty_upd;
    logic       breathing;

    typedef struct {
        int d;
        int u;
        int b;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 manual, 1 up, 2 hold hi, 3 down, 4 hold lo
    int m_st   = 0;
    int m_duty = 0;
    int m_left = ST - 1;
    int m_hold = 0;

    int strobe_val[$];
    int strobe_cyc[$];
    int cyc = 0;

    pwm_duty_sequencer #(
        .STEP_TICKS(ST),
        .STEP_SIZE (8'(SS)),
        .HOLD_STEPS(8'(HS))
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .key_pulse(key_pulse),
        .duty     (duty),
        .duty_upd (duty_upd),
        .breathing(breathing)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] k, input logic r);
        int  nd;
        int  ns;
        bit  br;
        bit  stp;
        if (r) begin
            m_st = 0; m_duty = 0; m_left = ST - 1; m_hold = 0;
            sb_q.push_back('{0, 0, 0});
            return;
        end
        br  = (m_st != 0);
        stp = br && (m_left == 0);
        nd  = m_duty;
        ns  = m_st;
        if (k[2]) begin
            if (br) ns = 0;
            else begin ns = 1; m_hold = 0; end
        end else if (k[3]) begin
            nd = 127; ns = 0;
        end else if (k[0]) begin
            nd = (m_duty + 10 > 255) ? 255 : m_duty + 10; ns = 0;
        end else if (k[1]) begin
            nd = (m_duty < 10) ? 0 : m_duty - 10; ns = 0;
        end else if (stp) begin
            if (m_st == 1) begin
                nd = (m_duty + SS > 255) ? 255 : m_duty + SS;
                if (nd == 255) ns = 2;
            end else if (m_st == 3) begin
                nd = (m_duty < SS) ? 0 : m_duty - SS;
                if (nd == 0) ns = 4;
            end else begin
                m_hold++;
                if (m_hold == HS) begin
                    m_hold = 0;
                    ns = (m_st == 2) ? 3 : 1;
                end
            end
        end
        if (ns == 0 || (k[2] && !br)) m_left = ST - 1;
        else m_left = (m_left == 0) ? ST - 1 : m_left - 1;
        sb_q.push_back('{nd, (nd != m_duty) ? 1 : 0, (ns != 0) ? 1 : 0});
        m_duty = nd;
        m_st   = ns;
    endtask

    // Compare last cycle's prediction, then drive the next inputs.
    task automatic cycle(input logic [3:0] k, input logic r);
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_duty", int'(duty), e.d);
            check("sb_upd", int'(duty_upd), e.u);
            check("sb_breath", int'(breathing), e.b);
        end
        if (duty_upd) begin
            strobe_val.push_back(int'(duty));
            strobe_cyc.push_back(cyc);
        end
        key_pulse = k;
        RST       = r;
        model_step(k, r);
    endtask

    task automatic press(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(k, 1'b0);
            cycle(4'b0000, 1'b0);
        end
    endtask

    initial begin
        int exp_seq[8];
        int hits;
        RST = 1'b1;
        key_pulse = 4'b0000;

        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
        check("rst_duty", int'(duty), 0);
        check("rst_upd", int'(duty_upd), 0);
        check("rst_breath", int'(breathing), 0);
        cycle(4'b0000, 1'b0);
        check("post_rst_upd", int'(duty_upd), 0);

        strobe_val.delete();
        press(4'b0001, 3);
        cycle(4'b0000, 1'b0);
        check("inc_n", strobe_val.size(), 3);
        check("inc_30", int'(duty), 30);
        if (strobe_val.size() == 3) begin
            check("inc_a", strobe_val[0], 10);
            check("inc_b", strobe_val[1], 20);
            check("inc_c", strobe_val[2], 30);
        end

        press(4'b0001, 22);
        check("at_250", int'(duty), 250);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("sat_hi", int'(duty), 255);
        check("sat_hi_upd", int'(duty_upd), 1);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("sat_hi_again", int'(duty), 255);
        check("sat_hi_noupd", int'(duty_upd), 0);
        press(4'b0010, 25);
        check("at_5", int'(duty), 5);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("sat_lo", int'(duty), 0);
        check("sat_lo_upd", int'(duty_upd), 1);

        strobe_val.delete();
        strobe_cyc.delete();
        cycle(4'b0100, 1'b0);
        for (int i = 0; i < 42; i++) cycle(4'b0000, 1'b0);
        exp_seq = '{64, 128, 192, 255, 191, 127, 63, 0};
        check("breath_n", strobe_val.size(), 8);
        if (strobe_val.size() >= 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("breath_%0d", i), strobe_val[i], exp_seq[i]);
            for (int i = 1; i < 4; i++)
                check($sformatf("gap_%0d", i),
                      strobe_cyc[i] - strobe_cyc[i-1], ST);
        end
        check("breath_flag", int'(breathing), 1);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        check("stop_breath", int'(breathing), 0);

        cycle(4'b1011, 1'b0);
        cycle(4'b0000, 1'b0);
        check("multi_key", int'(duty), 127);
        check("multi_manual", int'(breathing), 0);

        press(4'b0010, 13);
        check("back_to_0", int'(duty), 0);
        cycle(4'b0100, 1'b0);
        hits = 0;
        for (int i = 0; i < 200 && hits == 0; i++) begin
            if (m_st == 1 && m_duty == 128 && m_left == 0) hits = 1;
            else cycle(4'b0000, 1'b0);
        end
        check("wait_128", hits, 1);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("key_vs_step", int'(duty), 118);
        check("key_vs_step_br", int'(breathing), 0);

        cycle(4'b0100, 1'b0);
        hits = 0;
        for (int i = 0; i < 200 && hits == 0; i++) begin
            if (m_st == 2) hits = 1;
            cycle(4'b0000, 1'b0);
        end
        check("wait_hold_hi", hits, 1);
        cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b1);
        cycle(4'b0000, 1'b0);
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_breath", int'(breathing), 0);
        check("mid_rst_upd", int'(duty_upd), 0);
        cycle(4'b0000, 1'b0);
        check("mid_rst_after", int'(duty_upd), 0);

        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
